id_stage_fwd: RTL and testbench

Parametrised successor to the decode stage. It registers the fetch→decode payload and decodes the instruction. It reads rs/rt from the 2R1W `regfile`, resolves RAW hazards against `NFWD` downstream producer stages (bypass or interlock), resolves branches, and flags decode-time exceptions with a defined code. It sits between the IF stage and the EX stage on the standard valid/allowin pipeline handshake, and accepts a flush from the write-back/exception logic.

---
 rtl/id_stage_fwd_pkg.sv | 40 ++++
 rtl/id_stage_fwd_fwd_unit.sv | 45 ++++
 rtl/regfile.sv | 24 ++
 rtl/id_stage_fwd.sv | 206 ++++++++++++++++++++
 tb/tb_id_stage_fwd.sv | 399 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/id_stage_fwd_pkg.sv
// Shared widths, exception codes and bus layouts for the decode stage with forwarding.
package id_stage_fwd_pkg;

    localparam int FS_TO_DS_BUS_WD = 65;
    localparam int DS_TO_ES_BUS_WD = 142;
    localparam int BR_BUS_WD       = 33;
    localparam int WS_TO_RF_BUS_WD = 38;
    localparam int FWD_SLOT_WD     = 40;

    localparam logic [4:0] EXC_NONE = 5'h00;
    localparam logic [4:0] EXC_ADEL = 5'h04;
    localparam logic [4:0] EXC_SYS  = 5'h08;
    localparam logic [4:0] EXC_BP   = 5'h09;
    localparam logic [4:0] EXC_RI   = 5'h0a;

    typedef struct packed {
        logic        valid;
        logic        we;
        logic        data_ok;
        logic [4:0]  dest;
        logic [31:0] data;
    } fwd_slot_t;

    typedef struct packed {
        logic        ex_from_if;
        logic [31:0] inst;
        logic [31:0] pc;
    } fs_to_ds_t;

    // A fetch-side fault outranks anything the instruction itself would raise.
    function automatic logic [4:0] exc_code(input logic ex_if, input logic brk,
                                            input logic sys, input logic ri);
        if (ex_if)    return EXC_ADEL;
        else if (brk) return EXC_BP;
        else if (sys) return EXC_SYS;
        else if (ri)  return EXC_RI;
        return EXC_NONE;
    endfunction

endpackage

// File: rtl/id_stage_fwd_fwd_unit.sv
// Per-operand hazard resolution against the producer slots; ID_BYPASS_EN selects bypass vs interlock-only.
module id_fwd_unit
    import id_stage_fwd_pkg::*;
#(
    parameter int NFWD = 3
) (
    input  logic [NFWD*FWD_SLOT_WD-1:0] fwd_bus,
    input  logic [4:0]                  raddr,
    input  logic [31:0]                 rf_data,
    output logic [31:0]                 value,
    output logic                        stall
);

    logic        hit;
    logic        hit_ok;
    logic [31:0] hit_data;
    fwd_slot_t   slot;

    // Scan oldest to youngest so the lowest-index match is the one left standing.
    always_comb begin
        hit      = 1'b0;
        hit_ok   = 1'b0;
        hit_data = '0;
        slot     = '0;
        for (int k = NFWD - 1; k >= 0; k--) begin
            slot = fwd_slot_t'(fwd_bus[k*FWD_SLOT_WD +: FWD_SLOT_WD]);
            if (slot.valid && slot.we && (slot.dest == raddr) && (raddr != 5'd0)) begin
                hit      = 1'b1;
                hit_ok   = slot.data_ok;
                hit_data = slot.data;
            end
        end
    end

`ifdef ID_BYPASS_EN
    assign stall = hit & ~hit_ok;
    assign value = hit ? hit_data : rf_data;
`else
    logic unused_fwd;
    assign unused_fwd = hit_ok ^ (^hit_data);
    assign stall      = hit;
    assign value      = rf_data;
`endif

endmodule

// File: rtl/regfile.sv
// 32 x 32-bit register file, two combinational read ports and one write port; $0 reads zero.
module regfile (
    input  logic        clk,
    input  logic [4:0]  raddr1,
    output logic [31:0] rdata1,
    input  logic [4:0]  raddr2,
    output logic [31:0] rdata2,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata
);

    logic [31:0] rf [32];

    always_ff @(posedge clk) begin
        if (we) begin
            rf[waddr] <= wdata;
        end
    end

    assign rdata1 = (raddr1 == 5'd0) ? 32'd0 : rf[raddr1];
    assign rdata2 = (raddr2 == 5'd0) ? 32'd0 : rf[raddr2];

endmodule

// File: rtl/id_stage_fwd.sv
// Decode stage: payload register, decode, operand fetch with hazard resolution, branch resolve.
// Build option ID_BYPASS_EN enables forwarding from fwd_bus; otherwise every RAW match interlocks.
module id_stage_fwd
    import id_stage_fwd_pkg::*;
#(
    parameter int NFWD = 3
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        es_allowin,
    output logic                        ds_allowin,
    input  logic                        fs_to_ds_valid,
    input  logic [FS_TO_DS_BUS_WD-1:0]  fs_to_ds_bus,
    output logic                        ds_to_es_valid,
    output logic [DS_TO_ES_BUS_WD-1:0]  ds_to_es_bus,
    output logic [BR_BUS_WD-1:0]        br_bus,
    input  logic [WS_TO_RF_BUS_WD-1:0]  ws_to_rf_bus,
    input  logic [NFWD*FWD_SLOT_WD-1:0] fwd_bus,
    input  logic                        flush
);

    logic      ds_valid;
    fs_to_ds_t ds_r;
    logic      ds_ready_go;

    always_ff @(posedge clk) begin
        if (reset) begin
            ds_valid <= 1'b0;
            ds_r     <= '0;
        end else begin
            if (flush) begin
                ds_valid <= 1'b0;
            end else if (ds_allowin) begin
                ds_valid <= fs_to_ds_valid;
            end
            if (fs_to_ds_valid && ds_allowin && !flush) begin
                ds_r <= fs_to_ds_t'(fs_to_ds_bus);
            end
        end
    end

    logic [31:0] inst;
    logic [31:0] pc;
    logic [5:0]  op;
    logic [5:0]  func;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  sa;
    logic [15:0] imm;
    logic [25:0] jidx;

    assign inst = ds_r.inst;
    assign pc   = ds_r.pc;
    assign op   = inst[31:26];
    assign rs   = inst[25:21];
    assign rt   = inst[20:16];
    assign rd   = inst[15:11];
    assign sa   = inst[10:6];
    assign func = inst[5:0];
    assign imm  = inst[15:0];
    assign jidx = inst[25:0];

    logic r_clean;
    logic inst_addu, inst_subu, inst_slt, inst_sltu;
    logic inst_and, inst_or, inst_xor, inst_nor;
    logic inst_sll, inst_srl, inst_sra;
    logic inst_addiu, inst_lui, inst_lw, inst_sw;
    logic inst_beq, inst_bne, inst_jal, inst_jr;
    logic inst_syscall, inst_break;
    logic inst_r_alu, inst_shift, inst_known, inst_ri;

    assign r_clean      = (op == 6'h00) && (sa == 5'd0);
    assign inst_addu    = r_clean && (func == 6'h21);
    assign inst_subu    = r_clean && (func == 6'h23);
    assign inst_slt     = r_clean && (func == 6'h2a);
    assign inst_sltu    = r_clean && (func == 6'h2b);
    assign inst_and     = r_clean && (func == 6'h24);
    assign inst_or      = r_clean && (func == 6'h25);
    assign inst_xor     = r_clean && (func == 6'h26);
    assign inst_nor     = r_clean && (func == 6'h27);
    assign inst_sll     = (op == 6'h00) && (rs == 5'd0) && (func == 6'h00);
    assign inst_srl     = (op == 6'h00) && (rs == 5'd0) && (func == 6'h02);
    assign inst_sra     = (op == 6'h00) && (rs == 5'd0) && (func == 6'h03);
    assign inst_jr      = r_clean && (rt == 5'd0) && (rd == 5'd0) && (func == 6'h08);
    assign inst_syscall = (op == 6'h00) && (func == 6'h0c);
    assign inst_break   = (op == 6'h00) && (func == 6'h0d);
    assign inst_addiu   = (op == 6'h09);
    assign inst_lui     = (op == 6'h0f) && (rs == 5'd0);
    assign inst_lw      = (op == 6'h23);
    assign inst_sw      = (op == 6'h2b);
    assign inst_beq     = (op == 6'h04);
    assign inst_bne     = (op == 6'h05);
    assign inst_jal     = (op == 6'h03);

    assign inst_r_alu = inst_addu | inst_subu | inst_slt | inst_sltu
                      | inst_and | inst_or | inst_xor | inst_nor;
    assign inst_shift = inst_sll | inst_srl | inst_sra;
    assign inst_known = inst_r_alu | inst_shift | inst_addiu | inst_lui | inst_lw | inst_sw
                      | inst_beq | inst_bne | inst_jal | inst_jr | inst_syscall | inst_break;
    assign inst_ri    = ~inst_known;

    logic       ds_ex;
    logic [4:0] excode;

    assign ds_ex  = ds_r.ex_from_if | inst_break | inst_syscall | inst_ri;
    assign excode = exc_code(ds_r.ex_from_if, inst_break, inst_syscall, inst_ri);

    logic [11:0] alu_op;
    logic        src2_is_imm;
    logic        gr_we;
    logic        mem_we;
    logic [4:0]  dest;

    assign alu_op[0]  = inst_addu | inst_addiu | inst_lw | inst_sw | inst_jal;
    assign alu_op[1]  = inst_subu;
    assign alu_op[2]  = inst_slt;
    assign alu_op[3]  = inst_sltu;
    assign alu_op[4]  = inst_and;
    assign alu_op[5]  = inst_nor;
    assign alu_op[6]  = inst_or;
    assign alu_op[7]  = inst_xor;
    assign alu_op[8]  = inst_sll;
    assign alu_op[9]  = inst_srl;
    assign alu_op[10] = inst_sra;
    assign alu_op[11] = inst_lui;

    assign src2_is_imm = inst_addiu | inst_lui | inst_lw | inst_sw;
    assign gr_we       = ~ds_ex & ~(inst_sw | inst_beq | inst_bne | inst_jr);
    assign mem_we      = ~ds_ex & inst_sw;
    assign dest        = inst_jal ? 5'd31 :
                         (inst_addiu | inst_lui | inst_lw) ? rt : rd;

    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] rf_rdata1;
    logic [31:0] rf_rdata2;

    assign {rf_we, rf_waddr, rf_wdata} = ws_to_rf_bus;

    regfile u_regfile (
        .clk    (clk),
        .raddr1 (rs),
        .rdata1 (rf_rdata1),
        .raddr2 (rt),
        .rdata2 (rf_rdata2),
        .we     (rf_we),
        .waddr  (rf_waddr),
        .wdata  (rf_wdata)
    );

    logic [31:0] rs_value;
    logic [31:0] rt_value;
    logic        rs_stall;
    logic        rt_stall;

    id_fwd_unit #(.NFWD(NFWD)) u_fwd_rs (
        .fwd_bus (fwd_bus),
        .raddr   (rs),
        .rf_data (rf_rdata1),
        .value   (rs_value),
        .stall   (rs_stall)
    );

    id_fwd_unit #(.NFWD(NFWD)) u_fwd_rt (
        .fwd_bus (fwd_bus),
        .raddr   (rt),
        .rf_data (rf_rdata2),
        .value   (rt_value),
        .stall   (rt_stall)
    );

    logic use_rs;
    logic use_rt;
    logic stall;

    assign use_rs = ~(inst_shift | inst_lui | inst_jal);
    assign use_rt = inst_r_alu | inst_shift | inst_sw | inst_beq | inst_bne;
    // A faulting instruction goes straight to EX; its operands are never consumed.
    assign stall  = ~ds_ex & ((use_rs & rs_stall) | (use_rt & rt_stall));

    assign ds_ready_go    = ~stall;
    assign ds_allowin     = ~ds_valid | (ds_ready_go & es_allowin);
    assign ds_to_es_valid = ds_valid & ds_ready_go;

    logic        rs_eq_rt;
    logic [31:0] pc_plus4;
    logic        br_taken;
    logic [31:0] br_target;

    assign rs_eq_rt = (rs_value == rt_value);
    assign pc_plus4 = pc + 32'd4;
    assign br_taken = ds_valid & ds_ready_go & ~ds_ex
                    & ((inst_beq & rs_eq_rt) | (inst_bne & ~rs_eq_rt) | inst_jal | inst_jr);
    assign br_target = (inst_beq | inst_bne) ? pc_plus4 + {{14{imm[15]}}, imm, 2'b00} :
                       inst_jr               ? rs_value :
                                               {pc_plus4[31:28], jidx, 2'b00};
    assign br_bus = {br_taken, br_target};

    assign ds_to_es_bus = {ds_ex, excode, alu_op,
                           inst_lw, inst_shift, inst_jal, src2_is_imm, inst_jal,
                           gr_we, mem_we, dest, imm,
                           rs_value, rt_value, pc};

endmodule

// File: tb/tb_id_stage_fwd.sv
// Directed bench for id_stage_fwd with a spec-level decode/hazard model checked every cycle.
module tb_id_stage_fwd;

    localparam int NFWD = 3;
`ifdef ID_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    localparam int K_ALU = 0, K_SHIFT = 1, K_ADDIU = 2, K_LUI = 3, K_LW = 4, K_SW = 5,
                   K_BEQ = 6, K_BNE = 7, K_JAL = 8, K_JR = 9, K_SYS = 10, K_BRK = 11, K_RI = 12;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 es_allowin;
    logic                 ds_allowin;
    logic                 fs_to_ds_valid;
    logic [64:0]          fs_to_ds_bus;
    logic                 ds_to_es_valid;
    logic [141:0]         ds_to_es_bus;
    logic [32:0]          br_bus;
    logic [37:0]          ws_to_rf_bus;
    logic [NFWD*40-1:0]   fwd_bus;
    logic                 flush;

    logic        s_valid [NFWD];
    logic        s_we    [NFWD];
    logic        s_ok    [NFWD];
    logic [4:0]  s_dest  [NFWD];
    logic [31:0] s_data  [NFWD];

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_on  = 1'b0;

    always #5 clk = ~clk;

    id_stage_fwd #(.NFWD(NFWD)) dut (
        .clk            (clk),
        .reset          (reset),
        .es_allowin     (es_allowin),
        .ds_allowin     (ds_allowin),
        .fs_to_ds_valid (fs_to_ds_valid),
        .fs_to_ds_bus   (fs_to_ds_bus),
        .ds_to_es_valid (ds_to_es_valid),
        .ds_to_es_bus   (ds_to_es_bus),
        .br_bus         (br_bus),
        .ws_to_rf_bus   (ws_to_rf_bus),
        .fwd_bus        (fwd_bus),
        .flush          (flush)
    );

    always_comb begin
        fwd_bus = '0;
        for (int k = 0; k < NFWD; k++)
            fwd_bus[k*40 +: 40] = {s_valid[k], s_we[k], s_ok[k], s_dest[k], s_data[k]};
    end

    logic        b_ex, b_gr_we, b_mem_we;
    logic [4:0]  b_excode, b_dest;
    logic [15:0] b_imm;
    logic [31:0] b_rs, b_rt, b_pc;
    assign b_ex     = ds_to_es_bus[141];
    assign b_excode = ds_to_es_bus[140:136];
    assign b_gr_we  = ds_to_es_bus[118];
    assign b_mem_we = ds_to_es_bus[117];
    assign b_dest   = ds_to_es_bus[116:112];
    assign b_imm    = ds_to_es_bus[111:96];
    assign b_rs     = ds_to_es_bus[95:64];
    assign b_rt     = ds_to_es_bus[63:32];
    assign b_pc     = ds_to_es_bus[31:0];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit          m_valid;
    bit          m_exif;
    logic [31:0] m_inst;
    logic [31:0] m_pc;
    logic [31:0] rf_m [32];

    int          d_kind;
    logic [5:0]  d_op, d_fn;
    logic [4:0]  d_rs, d_rt, d_rd, d_sa;
    bit          d_urs, d_urt, rs_hit, rt_hit, rs_st, rt_st, m_stall;
    logic [31:0] pc4;

    bit          e_allowin, e_valid, e_taken, e_ex, e_gr_we, e_mem_we;
    logic [31:0] e_target, e_rs, e_rt;
    logic [4:0]  e_excode, e_dest;

    always_comb begin
        d_op = m_inst[31:26]; d_rs = m_inst[25:21]; d_rt = m_inst[20:16];
        d_rd = m_inst[15:11]; d_sa = m_inst[10:6];  d_fn = m_inst[5:0];
        d_kind = K_RI;
        case (d_op)
            6'h00: case (d_fn)
                6'h21, 6'h23, 6'h2a, 6'h2b, 6'h24, 6'h25, 6'h26, 6'h27:
                        if (d_sa == 0) d_kind = K_ALU;
                6'h00, 6'h02, 6'h03: if (d_rs == 0) d_kind = K_SHIFT;
                6'h08: if (d_rt == 0 && d_rd == 0 && d_sa == 0) d_kind = K_JR;
                6'h0c: d_kind = K_SYS;
                6'h0d: d_kind = K_BRK;
                default: d_kind = K_RI;
            endcase
            6'h09: d_kind = K_ADDIU;
            6'h0f: if (d_rs == 0) d_kind = K_LUI;
            6'h23: d_kind = K_LW;
            6'h2b: d_kind = K_SW;
            6'h04: d_kind = K_BEQ;
            6'h05: d_kind = K_BNE;
            6'h03: d_kind = K_JAL;
            default: d_kind = K_RI;
        endcase

        e_ex = m_exif || d_kind == K_SYS || d_kind == K_BRK || d_kind == K_RI;
        e_excode = m_exif ? 5'h04 : d_kind == K_BRK ? 5'h09 : d_kind == K_SYS ? 5'h08 :
                   d_kind == K_RI ? 5'h0a : 5'h00;
        d_urs = !(d_kind == K_SHIFT || d_kind == K_LUI || d_kind == K_JAL);
        d_urt = d_kind == K_ALU || d_kind == K_SHIFT || d_kind == K_SW ||
                d_kind == K_BEQ || d_kind == K_BNE;

        rs_hit = 0; rs_st = 0; e_rs = (d_rs == 0) ? 32'd0 : rf_m[d_rs];
        rt_hit = 0; rt_st = 0; e_rt = (d_rt == 0) ? 32'd0 : rf_m[d_rt];
        for (int k = 0; k < NFWD; k++) begin
            if (!rs_hit && s_valid[k] && s_we[k] && s_dest[k] == d_rs && d_rs != 0) begin
                rs_hit = 1;
                rs_st  = BYP ? !s_ok[k] : 1'b1;
                if (BYP) e_rs = s_data[k];
            end
            if (!rt_hit && s_valid[k] && s_we[k] && s_dest[k] == d_rt && d_rt != 0) begin
                rt_hit = 1;
                rt_st  = BYP ? !s_ok[k] : 1'b1;
                if (BYP) e_rt = s_data[k];
            end
        end

        m_stall   = !e_ex && ((d_urs && rs_st) || (d_urt && rt_st));
        e_allowin = !m_valid || (!m_stall && es_allowin);
        e_valid   = m_valid && !m_stall;
        e_taken   = e_valid && !e_ex && ((d_kind == K_BEQ && e_rs == e_rt) ||
                    (d_kind == K_BNE && e_rs != e_rt) || d_kind == K_JAL || d_kind == K_JR);
        pc4       = m_pc + 32'd4;
        e_target  = (d_kind == K_JR) ? e_rs :
                    (d_kind == K_JAL) ? {pc4[31:28], m_inst[25:0], 2'b00} :
                    pc4 + {{14{m_inst[15]}}, m_inst[15:0], 2'b00};
        e_dest    = (d_kind == K_JAL) ? 5'd31 :
                    (d_kind == K_ADDIU || d_kind == K_LUI || d_kind == K_LW) ? d_rt : d_rd;
        e_gr_we   = !e_ex && !(d_kind == K_SW || d_kind == K_BEQ || d_kind == K_BNE || d_kind == K_JR);
        e_mem_we  = !e_ex && d_kind == K_SW;
    end

    always @(posedge clk) begin
        bit al;
        al = e_allowin;
        if (reset) begin
            m_valid = 0; m_exif = 0; m_inst = '0; m_pc = '0;
        end else begin
            if (fs_to_ds_valid && al && !flush) begin
                m_exif = fs_to_ds_bus[64];
                m_inst = fs_to_ds_bus[63:32];
                m_pc   = fs_to_ds_bus[31:0];
            end
            if (flush) m_valid = 0;
            else if (al) m_valid = fs_to_ds_valid;
        end
        if (ws_to_rf_bus[37]) rf_m[ws_to_rf_bus[36:32]] = ws_to_rf_bus[31:0];
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("cmp_valid",   32'(ds_to_es_valid), 32'(e_valid));
            chk("cmp_allowin", 32'(ds_allowin),     32'(e_allowin));
            chk("cmp_br",      32'(br_bus[32]),     32'(e_taken));
            if (e_taken) chk("cmp_target", br_bus[31:0], e_target);
            if (e_valid) begin
                chk("cmp_ex",     32'(b_ex),     32'(e_ex));
                chk("cmp_excode", 32'(b_excode), 32'(e_excode));
                chk("cmp_gr_we",  32'(b_gr_we),  32'(e_gr_we));
                chk("cmp_mem_we", 32'(b_mem_we), 32'(e_mem_we));
                chk("cmp_dest",   32'(b_dest),   32'(e_dest));
                chk("cmp_imm",    32'(b_imm),    32'(m_inst[15:0]));
                chk("cmp_rs",     b_rs,          e_rs);
                chk("cmp_rt",     b_rt,          e_rt);
                chk("cmp_pc",     b_pc,          m_pc);
            end
        end
    end

    // ---------------- stimulus ----------------
    function automatic logic [31:0] rtype(input logic [4:0] rs, rt, rd, sa, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, sa, fn};
    endfunction
    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs, rt,
                                          input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_slot(input int k, input bit ok, input logic [4:0] dest, input logic [31:0] data);
        s_valid[k] = 1; s_we[k] = 1; s_ok[k] = ok; s_dest[k] = dest; s_data[k] = data;
    endtask

    task automatic clear_slots();
        for (int k = 0; k < NFWD; k++) begin
            s_valid[k] = 0; s_we[k] = 0; s_ok[k] = 0; s_dest[k] = 0; s_data[k] = 0;
        end
    endtask

    task automatic rf_write(input logic [4:0] r, input logic [31:0] v);
        ws_to_rf_bus = {1'b1, r, v};
        tick();
        ws_to_rf_bus = '0;
    endtask

    task automatic issue(input bit exif, input logic [31:0] inst, input logic [31:0] pc);
        fs_to_ds_valid = 1;
        fs_to_ds_bus   = {exif, inst, pc};
        tick();
        fs_to_ds_valid = 0;
        #1;
    endtask

    initial begin
        reset = 1; es_allowin = 1; fs_to_ds_valid = 0; fs_to_ds_bus = '0;
        ws_to_rf_bus = '0; flush = 0;
        clear_slots();
        for (int i = 0; i < 32; i++) rf_m[i] = '0;
        tick();
        chk_on = 1;
        tick();
        reset = 0;
        #1;
        chk("rst_valid",   32'(ds_to_es_valid), 32'd0);
        chk("rst_allowin", 32'(ds_allowin),     32'd1);
        chk("rst_br",      32'(br_bus[32]),     32'd0);
        chk("rst_ds_ex",   32'(b_ex),           32'd0);

        for (int i = 1; i < 32; i++) rf_write(5'(i), 32'hA000_0000 + 32'(i));
        rf_write(5'd2, 32'h22);
        rf_write(5'd6, 32'h22);
        rf_write(5'd5, 32'h1234);

        // addu $3,$1,$2 with a completed producer of $1 in slot 0
        set_slot(0, 1, 5'd1, 32'h11);
        issue(0, rtype(1, 2, 3, 0, 6'h21), 32'hbfc0_0000);
        chk("addu_valid", 32'(ds_to_es_valid), 32'(BYP));
        chk("addu_rs",    b_rs, BYP ? 32'h11 : 32'hA000_0001);
        chk("addu_rt",    b_rt, 32'h22);
        clear_slots();
        tick();

        // load in flight in slot 0 shadows a ready value in slot 2
        set_slot(0, 0, 5'd1, 32'h99);
        set_slot(2, 1, 5'd1, 32'h55);
        issue(0, rtype(1, 0, 4, 0, 6'h21), 32'hbfc0_0010);
        fs_to_ds_valid = 1;
        fs_to_ds_bus   = {1'b0, itype(6'h2b, 2, 3, 16'h0008), 32'hbfc0_0014};
        #1;
        chk("ld_valid",   32'(ds_to_es_valid), 32'd0);
        chk("ld_allowin", 32'(ds_allowin),     32'd0);
        repeat (3) tick();
        chk("ld_hold_allowin", 32'(ds_allowin), 32'd0);
        chk("ld_hold_pc",      b_pc,            32'hbfc0_0010);
        set_slot(0, 1, 5'd1, 32'h77);
        #1;
        chk("ld_ok_valid", 32'(ds_to_es_valid), 32'(BYP));
        chk("ld_ok_rs",    b_rs, BYP ? 32'h77 : 32'hA000_0001);
        clear_slots();
        #1;
        chk("ld_clr_valid", 32'(ds_to_es_valid), 32'd1);
        tick();
        fs_to_ds_valid = 0;
        #1;
        chk("sw_mem_we", 32'(b_mem_we), 32'd1);
        chk("sw_pc",     b_pc,          32'hbfc0_0014);
        tick();

        // branches
        issue(0, itype(6'h04, 2, 6, 16'h0004), 32'hbfc0_0100);
        chk("beq_taken",  32'(br_bus[32]), 32'd1);
        chk("beq_target", br_bus[31:0],    32'hbfc0_0114);
        tick();
        set_slot(1, 1, 5'd2, 32'h22);
        issue(0, itype(6'h04, 2, 6, 16'h0004), 32'hbfc0_0100);
        chk("beq_slot_taken", 32'(br_bus[32]), 32'(BYP));
        clear_slots();
        #1;
        chk("beq_rel_taken", 32'(br_bus[32]), 32'd1);
        tick();
        issue(0, itype(6'h05, 2, 6, 16'h0004), 32'hbfc0_0120);
        chk("bne_taken", 32'(br_bus[32]), 32'd0);
        tick();
        set_slot(0, 0, 5'd0, 32'hdead);
        issue(0, itype(6'h04, 0, 0, 16'hfffe), 32'hbfc0_0200);
        chk("beq0_valid",  32'(ds_to_es_valid), 32'd1);
        chk("beq0_target", br_bus[31:0],        32'hbfc0_01fc);
        clear_slots();
        tick();
        issue(0, {6'h03, 26'h40}, 32'hbfc0_0300);
        chk("jal_target", br_bus[31:0], 32'hb000_0100);
        chk("jal_dest",   32'(b_dest),  32'd31);
        tick();
        issue(0, rtype(5, 0, 0, 0, 6'h08), 32'hbfc0_0400);
        chk("jr_target", br_bus[31:0], 32'h1234);
        tick();

        // exceptions
        set_slot(0, 0, 5'd1, 32'h0);
        issue(0, 32'hfc20_0000, 32'hbfc0_0500);
        chk("ri_valid",  32'(ds_to_es_valid), 32'd1);
        chk("ri_excode", 32'(b_excode),       32'h0a);
        chk("ri_gr_we",  32'(b_gr_we),        32'd0);
        clear_slots();
        tick();
        issue(1, 32'h0000_000c, 32'hbfc0_0504);
        chk("sys_if_excode", 32'(b_excode), 32'h04);
        tick();
        issue(0, 32'h0000_000c, 32'hbfc0_0508);
        chk("sys_excode", 32'(b_excode), 32'h08);
        tick();
        issue(0, 32'h0000_000d, 32'hbfc0_050c);
        chk("brk_excode", 32'(b_excode), 32'h09);
        tick();
        issue(1, 32'h0000_000d, 32'hbfc0_0510);
        tick();
        issue(0, rtype(1, 2, 3, 5, 6'h21), 32'hbfc0_0514);
        chk("sa_ri_excode", 32'(b_excode), 32'h0a);
        tick();
        issue(1, itype(6'h04, 2, 6, 16'h0004), 32'hbfc0_0518);
        chk("exbr_taken", 32'(br_bus[32]), 32'd0);
        tick();

        // flush, with and without a held instruction
        fs_to_ds_valid = 1;
        fs_to_ds_bus   = {1'b0, rtype(1, 2, 3, 0, 6'h21), 32'hbfc0_0600};
        flush = 1;
        tick();
        flush = 0; fs_to_ds_valid = 0;
        #1;
        chk("flush_valid", 32'(ds_to_es_valid), 32'd0);
        set_slot(0, 0, 5'd1, 32'h0);
        issue(0, rtype(1, 0, 4, 0, 6'h21), 32'hbfc0_0604);
        chk("fl_stall_allowin", 32'(ds_allowin), 32'd0);
        flush = 1;
        tick();
        flush = 0;
        #1;
        chk("fl_stall_allowin2", 32'(ds_allowin), 32'd1);
        issue(0, rtype(1, 0, 4, 0, 6'h21), 32'hbfc0_0608);
        reset = 1;
        tick();
        reset = 0;
        #1;
        chk("rst_stall_valid",   32'(ds_to_es_valid), 32'd0);
        chk("rst_stall_allowin", 32'(ds_allowin),     32'd1);
        clear_slots();

        // EX back-pressure
        es_allowin = 0;
        issue(0, rtype(1, 2, 3, 0, 6'h21), 32'hbfc0_0700);
        chk("bp_valid",   32'(ds_to_es_valid), 32'd1);
        chk("bp_allowin", 32'(ds_allowin),     32'd0);
        tick();
        chk("bp_pc", b_pc, 32'hbfc0_0700);
        es_allowin = 1;
        tick();

        // regfile write and read of $7 in the same cycle
        set_slot(2, 1, 5'd7, 32'h7777);
        issue(0, rtype(7, 0, 8, 0, 6'h21), 32'hbfc0_0800);
        ws_to_rf_bus = {1'b1, 5'd7, 32'h7777};
        #1;
        chk("ws_valid", 32'(ds_to_es_valid), 32'(BYP));
        chk("ws_rs",    b_rs, BYP ? 32'h7777 : 32'hA000_0007);
        tick();
        ws_to_rf_bus = '0;
        clear_slots();
        #1;
        chk("ws_after_valid", 32'(ds_to_es_valid), 32'(!BYP));
        chk("ws_after_rs",    b_rs,                32'h7777);
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
